// File: rtl/wb_pkg.sv
// Shared widths, FSM encoding and constants for the CPU-side Wishbone initiator.
package wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } wb_state_e;

  localparam logic [WB_DW-1:0] WB_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [WB_SW-1:0] SEL_ALL     = '1;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Saturating ack watchdog: counts enabled cycles since clear; expired once TIMEOUT-1 is reached.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/cpu_wb_master.sv
// CPU level-handshake request -> single Wishbone classic cycle; strobe 1 cycle after request, ready 1 cycle after ack.
// Ready is held until the CPU drops its request; WB_TIMEOUT_EN adds an ack watchdog with bus_err/ERR_DATA.
module cpu_wb_master
  import wb_pkg::*;
#(
  parameter int            DW       = WB_DW,
  parameter int            AW       = WB_AW,
  parameter int            TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(WB_ERR_DATA)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_ready,
  output logic [AW-1:0]   m_adr_o,
  output logic [DW-1:0]   m_dat_o,
  input  logic [DW-1:0]   m_dat_i,
  output logic [DW/8-1:0] m_sel_o,
  output logic            m_we_o,
  output logic            m_stb_o,
  input  logic            m_ack_i,
  output logic            bus_err
);

  localparam int SW = DW / 8;

  wb_state_e       state_q, state_n;
  logic [AW-1:0]   adr_n;
  logic [DW-1:0]   dat_n, rdata_n;
  logic [SW-1:0]   sel_n;
  logic            we_n, stb_n, ready_n, err_q, err_n, abort_q, abort_n;
  logic            accept, wd_expired, abort_now;

  assign accept = (state_q == IDLE) && cpu_req && !cpu_ready;

`ifdef WB_TIMEOUT_EN
  wb_ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      ((state_q == BUS) && !m_ack_i),
    .expired (wd_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT[0];
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_sel_o   <= '0;
      m_we_o    <= 1'b0;
      m_stb_o   <= 1'b0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      m_adr_o   <= adr_n;
      m_dat_o   <= dat_n;
      m_sel_o   <= sel_n;
      m_we_o    <= we_n;
      m_stb_o   <= stb_n;
      cpu_rdata <= rdata_n;
      cpu_ready <= ready_n;
      err_q     <= err_n;
      abort_q   <= abort_n;
    end
  end

  // A request dropped mid-cycle still finishes on the bus but never raises ready.
  assign abort_now = abort_q || !cpu_req;

  always_comb begin
    state_n = state_q;
    adr_n   = m_adr_o;
    dat_n   = m_dat_o;
    sel_n   = m_sel_o;
    we_n    = m_we_o;
    stb_n   = m_stb_o;
    rdata_n = cpu_rdata;
    ready_n = cpu_ready;
    err_n   = err_q;
    abort_n = abort_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          adr_n   = cpu_addr;
          dat_n   = cpu_wdata;
          we_n    = cpu_we;
          sel_n   = {SW{1'b1}};
          stb_n   = 1'b1;
          err_n   = 1'b0;
          abort_n = 1'b0;
          state_n = BUS;
        end
      end
      BUS: begin
        abort_n = abort_now;
        // Ack beats a watchdog expiry landing on the same cycle.
        if (m_ack_i || wd_expired) begin
          stb_n = 1'b0;
          if (!m_we_o) rdata_n = m_ack_i ? m_dat_i : ERR_DATA;
          if (!m_ack_i) err_n = 1'b1;
          if (abort_now) begin
            state_n = IDLE;
          end else begin
            ready_n = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!cpu_req) begin
          ready_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_err = err_q;

endmodule

// File: doc/cpu_wb_master.md
Name: cpu_wb_master

Overview:
- Initiator-side bridge that converts the multi-cycle CPU's level-held memory/IO request into single Wishbone classic cycles on the interconnect's master 0 port.
- Returns read data and a ready indication to the CPU (CPU `MIO_ready` input).
- Runs on the 100 MHz system clock. The CPU runs on a divided clock and holds its request until it sees ready, so the two sides use a four-phase level handshake.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- TIMEOUT, 64, ack watchdog limit in clk cycles (2..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  CPU bus request (`CPU_MIO`), level, held until cpu_ready.
- cpu_we  in  1  write request (`mem_w`), sampled with cpu_req.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data to CPU.
- cpu_ready  out  1  transaction complete; held until cpu_req falls.
- m_adr_o  out  AW  Wishbone address.
- m_dat_o  out  DW  Wishbone write data.
- m_dat_i  in  DW  Wishbone read data.
- m_sel_o  out  DW/8  byte selects.
- m_we_o  out  1  Wishbone write enable.
- m_stb_o  out  1  Wishbone strobe.
- m_ack_i  in  1  Wishbone acknowledge.
- bus_err  out  1  sticky timeout flag; cleared by the next accepted request.

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - m_stb_o=0, m_we_o=0, m_adr_o=0, m_dat_o=0, m_sel_o=0.
  - cpu_rdata=0, cpu_ready=0, bus_err=0.
  - Watchdog counter is 0.
- All other state changes occur on the clk rising edge.
- FSM states: IDLE, BUS, HOLD.
- IDLE:
  - Transitions when cpu_req=1 and cpu_ready=0.
  - Registers m_adr_o=cpu_addr, m_dat_o=cpu_wdata, m_we_o=cpu_we, m_sel_o=all ones.
  - Sets m_stb_o=1, clears bus_err and the counter, then moves to BUS.
  - Bus strobe rises 1 cycle after cpu_req is seen.
- BUS:
  - m_stb_o stays high; address, data and we are stable.
  - On m_ack_i=1:
    - m_stb_o=0.
    - On a read, cpu_rdata=m_dat_i. On a write, cpu_rdata is unchanged.
    - cpu_ready=1 the next cycle; go to HOLD.
  - Minimum latency from cpu_req to cpu_ready is 2 cycles when ack comes in the first BUS cycle.
  - Otherwise the counter increments each cycle.
  - Timeout: when the counter reaches TIMEOUT-1 without ack:
    - m_stb_o=0, bus_err=1, cpu_ready=1.
    - cpu_rdata=ERR_DATA on reads; go to HOLD.
  - An ack arriving on the same cycle as the timeout wins; it is treated as a normal ack.
  - cpu_req dropping in BUS (protocol violation): the bus cycle is still completed (wait for ack or timeout), then go directly to IDLE with cpu_ready never asserted.
- HOLD:
  - cpu_ready=1 until cpu_req=0, then cpu_ready=0 and return to IDLE.
  - A new request is accepted no earlier than the cycle after cpu_ready falls.
  - A request held continuously never starts a second bus cycle.
- m_ack_i seen while in IDLE or HOLD is ignored.
- Strobe protocol: m_stb_o is never high for more than one transaction, and address/we never change while it is high.
- Counter width is $clog2(TIMEOUT)+1 bits and saturates rather than wrapping.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined: watchdog, bus_err and the ERR_DATA path are present as described.
- Undefined:
  - No counter is built; BUS waits indefinitely for m_ack_i.
  - bus_err is tied to 0.
  - TIMEOUT and ERR_DATA are unused.

Decomposition:
- Shared package wb_pkg holds:
  - bus widths (DW, AW, SW=DW/8);
  - the FSM state enum (IDLE/BUS/HOLD) and its encoding;
  - constant ERR_DATA;
  - constant SEL_ALL (all-ones select).
- One natural sub-module: wb_ack_watchdog (counter, clear, enable, expired output), instantiated only under WB_TIMEOUT_EN.
- The FSM and datapath registers stay in cpu_wb_master.

Test Plan:
- Read: cpu_req=1, cpu_we=0, cpu_addr=32'h0000_0010; slave acks the first BUS cycle with m_dat_i=32'h1234_5678.
  - Expect m_stb_o high exactly 1 cycle, m_we_o=0, m_sel_o=4'hF.
  - Expect cpu_rdata=32'h1234_5678 and cpu_ready=1 two cycles after the request.
- Write with 5-cycle slave wait: cpu_we=1, cpu_addr=32'hFFFF_FF00, cpu_wdata=32'h0000_00A5.
  - Expect m_stb_o held 6 cycles with m_dat_o stable, then cpu_ready=1 and cpu_rdata unchanged.
- Timeout (TIMEOUT=8, macro defined): read with no ack.
  - Expect m_stb_o to drop after 8 cycles, bus_err=1, cpu_rdata=32'hDEAD_BEEF, cpu_ready=1.
  - The next request clears bus_err.
- Handshake: hold cpu_req high for 20 cycles after ready.
  - Expect exactly one strobe pulse.
  - Drop cpu_req: cpu_ready falls the next cycle. Reassert: a new cycle starts.
- Reset mid-BUS: assert rst asynchronously while m_stb_o=1.
  - Expect m_stb_o=0 and cpu_ready=0 without waiting for a clock edge.
  - After release, the FSM is in IDLE and a late m_ack_i is ignored.
- Aborted request: drop cpu_req in BUS; ack after 3 cycles.
  - Expect the bus cycle to complete, cpu_ready never asserted, and return to IDLE.
